// File: rtl/ifetch_prefetch_queue_if.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch_queue_if
//   Bundles the byte-wide instruction-memory port, the redirect request and
//   the decode-side valid/ready handshake of the instruction prefetch queue.
//
//   master : the fetch unit (drives imem_rd/imem_addr and the out_* side)
//   slave  : the environment (instruction memory, branch unit, decode)
//
//   imem_rd      fetch -> mem     byte read strobe
//   imem_addr    fetch -> mem     byte address, data returns next cycle
//   imem_data    mem   -> fetch   read byte
//   redirect     env   -> fetch   flush and restart at redirect_pc
//   redirect_pc  env   -> fetch   new PC (low two bits ignored)
//   out_valid    fetch -> decode  head entry valid
//   out_ready    decode-> fetch   head accepted when out_valid & out_ready
//   out_instr    fetch -> decode  head instruction
//   out_pc       fetch -> decode  PC of head instruction
//   count        fetch -> env     FIFO occupancy
// ---------------------------------------------------------------------------
interface ifetch_prefetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_data;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic [CW-1:0]     count;

    modport master (
        output imem_rd, imem_addr, out_valid, out_instr, out_pc, count,
        input  imem_data, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_rd, imem_addr, out_valid, out_instr, out_pc, count,
        output imem_data, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/ifetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_prefetch_queue
//   Instruction fetch stage. Reads the byte-wide instruction memory one byte
//   per cycle, assembles big-endian 32-bit words (byte at pc -> [31:24]),
//   buffers them with their PC in a small circular FIFO and presents the
//   head to decode over valid/ready. A redirect flushes everything and
//   restarts fetch at the new word-aligned PC.
//
//   Ports
//     clk    clock, all state updates on posedge
//     reset  asynchronous active-high reset, clears all state
//     bus    ifetch_prefetch_queue_if.master (memory, redirect, decode side)
//
//   Parameters
//     DEPTH     FIFO entries (power of two, >= 2)
//     ADDR_W    instruction memory byte-address width
//     RESET_PC  fetch PC after reset (word aligned)
// ---------------------------------------------------------------------------
module ifetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    ifetch_prefetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        ASM  = 1'b1
    } state_t;

    // Fetch FSM state
    state_t      state_reg, state_next;
    logic [1:0]  k_reg, k_next;          // next byte index to issue; 0 in ASM = byte3 returning
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [23:0] asm_reg;                // bytes 0..2 of the word being assembled

    // FIFO storage and bookkeeping
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   last_instr_reg, last_pc_reg;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              push;
    logic              pop;
    logic [31:0]       push_instr;
    logic [DEPTH-1:0]  we_vec;

    assign push_instr = {asm_reg, bus.imem_data};
    assign pop        = (count_reg != '0) && bus.out_ready && !bus.redirect;

    // -----------------------------------------------------------------------
    // Fetch FSM: next state, read issue and push decision
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        k_next        = k_reg;
        fetch_pc_next = fetch_pc_reg;
        rd_req        = 1'b0;
        rd_addr       = fetch_pc_reg[ADDR_W-1:0];
        push          = 1'b0;

        if (bus.redirect) begin
            // Redirect wins over everything: drop the word in flight and
            // any push that would have completed this cycle.
            state_next    = IDLE;
            k_next        = 2'd0;
            fetch_pc_next = bus.redirect_pc & ~32'h0000_0003;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Start a word only if a slot is free for it, so the
                    // push four cycles later can never hit a full FIFO.
                    if (count_reg < CW'(DEPTH)) begin
                        rd_req     = 1'b1;
                        k_next     = 2'd1;
                        state_next = ASM;
                    end
                end
                ASM: begin
                    if (k_reg != 2'd0) begin
                        rd_req  = 1'b1;
                        rd_addr = fetch_pc_reg[ADDR_W-1:0] + ADDR_W'(k_reg);
                        k_next  = k_reg + 2'd1;
                    end else begin
                        // Byte3 returns now: push the word. The next word may
                        // start in the same cycle only if a slot remains after
                        // this push (pop this cycle is deliberately ignored).
                        push          = 1'b1;
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                        if (count_reg < CW'(DEPTH - 1)) begin
                            rd_req  = 1'b1;
                            rd_addr = fetch_pc_reg[ADDR_W-1:0] + ADDR_W'(4);
                            k_next  = 2'd1;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Reads are blocked while reset is held so nothing is issued before the
    // first cycle after release.
    assign bus.imem_rd   = rd_req & ~reset;
    assign bus.imem_addr = bus.imem_rd ? rd_addr : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            k_reg        <= 2'd0;
            fetch_pc_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            k_reg        <= k_next;
            fetch_pc_reg <= fetch_pc_next;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO datapath
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign we_vec[gi] = push && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_reg        <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            last_instr_reg <= '0;
            last_pc_reg    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
                pc_mem[i]    <= '0;
            end
        end else begin
            // Shift in whatever byte returns while assembling; the byte that
            // lands the cycle after a redirect is never looked at because the
            // FSM is back in IDLE.
            if (state_reg == ASM && !bus.redirect) begin
                asm_reg <= {asm_reg[15:0], bus.imem_data};
            end

            for (int i = 0; i < DEPTH; i++) begin
                if (we_vec[i]) begin
                    instr_mem[i] <= push_instr;
                    pc_mem[i]    <= fetch_pc_reg;
                end
            end

            if (bus.redirect) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_reg     <= rd_ptr_reg + PW'(1);
                    last_instr_reg <= instr_mem[rd_ptr_reg];
                    last_pc_reg    <= pc_mem[rd_ptr_reg];
                end
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
        end
    end

    // Head is shown combinationally; when empty the last popped entry is held.
    assign bus.out_valid = (count_reg != '0);
    assign bus.out_instr = (count_reg != '0) ? instr_mem[rd_ptr_reg] : last_instr_reg;
    assign bus.out_pc    = (count_reg != '0) ? pc_mem[rd_ptr_reg]    : last_pc_reg;
    assign bus.count     = count_reg;
endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
module tb_ifetch_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 5;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic reset;

    ifetch_prefetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus_if ();

    ifetch_prefetch_queue #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-wide instruction memory: data returns the cycle after the read.
    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (bus_if.imem_rd) bus_if.imem_data <= mem[bus_if.imem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;
    int cyc;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Expected output stream: {pc, instr}, refilled whenever fetch restarts.
    logic [63:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        logic [4:0] a;
        a = pc[4:0];
        return {mem[a], mem[a + 5'd1], mem[a + 5'd2], mem[a + 5'd3]};
    endfunction

    task automatic restart_stream(input logic [31:0] pc);
        logic [31:0] p;
        p = pc & 32'hFFFF_FFFC;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            exp_q.push_back({p, word_at(p)});
            p = p + 32'd4;
        end
    endtask

    // Monitor / scoreboard: samples on the falling edge.
    logic prev_redirect = 1'b0;
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset) begin
            prev_redirect <= 1'b0;
        end else begin
            check("count_le_depth", 64'(bus_if.count <= 3'(DEPTH)), 64'd1);
            check("valid_vs_count", 64'(bus_if.out_valid), 64'(bus_if.count != 3'd0));
            if (prev_redirect) begin
                check("after_redirect_valid", 64'(bus_if.out_valid), 64'd0);
            end
            if (bus_if.out_valid && bus_if.out_ready && !bus_if.redirect) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    n_pops++;
                    $display("pop pc=%08h instr=%08h exp_pc=%08h exp_instr=%08h",
                             bus_if.out_pc, bus_if.out_instr, e[63:32], e[31:0]);
                    check("pop_pc", 64'(bus_if.out_pc), 64'(e[63:32]));
                    check("pop_instr", 64'(bus_if.out_instr), 64'(e[31:0]));
                end
            end
            prev_redirect <= bus_if.redirect;
        end
    end

    task automatic wait_cycle(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_imem_rd"},   64'(bus_if.imem_rd),   64'd0);
        check({tag, "_imem_addr"}, 64'(bus_if.imem_addr), 64'd0);
        check({tag, "_out_valid"}, 64'(bus_if.out_valid), 64'd0);
        check({tag, "_out_instr"}, 64'(bus_if.out_instr), 64'd0);
        check({tag, "_out_pc"},    64'(bus_if.out_pc),    64'd0);
        check({tag, "_count"},     64'(bus_if.count),     64'd0);
    endtask

    initial begin
        logic        found;
        int          pops0;
        int          ready_pct;
        logic [31:0] pend_pc;

        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h8C; mem[1] = 8'h22; mem[2] = 8'h00; mem[3] = 8'h04;
        mem[4] = 8'h00; mem[5] = 8'h85; mem[6] = 8'h30; mem[7] = 8'h20;

        reset = 1'b1;
        bus_if.redirect    = 1'b0;
        bus_if.redirect_pc = 32'd0;
        bus_if.out_ready   = 1'b1;
        ready_pct = 100;
        pend_pc   = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // First words after reset
        @(posedge clk); #1;
        reset = 1'b0;
        restart_stream(RESET_PC);
        wait_cycle(0);
        check("first_rd", 64'(bus_if.imem_rd), 64'd1);
        check("first_addr", 64'(bus_if.imem_addr), 64'd0);
        wait_cycle(4);
        check("c4_valid", 64'(bus_if.out_valid), 64'd0);
        wait_cycle(5);
        check("c5_valid", 64'(bus_if.out_valid), 64'd1);
        check("c5_instr", 64'(bus_if.out_instr), 64'h8C220004);
        check("c5_pc", 64'(bus_if.out_pc), 64'h0);
        wait_cycle(8);
        check("c8_valid", 64'(bus_if.out_valid), 64'd0);
        wait_cycle(9);
        check("c9_valid", 64'(bus_if.out_valid), 64'd1);
        check("c9_instr", 64'(bus_if.out_instr), 64'h00853020);
        check("c9_pc", 64'(bus_if.out_pc), 64'h4);

        // Consumer stalls: FIFO fills to DEPTH and fetch stops
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        for (int c = 30; c <= 50; c++) begin
            wait_cycle(c);
            check("stall_no_read", 64'(bus_if.imem_rd), 64'd0);
        end
        check("stall_count", 64'(bus_if.count), 64'(DEPTH));
        check("stall_head_pc", 64'(bus_if.out_pc), 64'h8);
        @(posedge clk); #1;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        check("pop_cycle_no_read", 64'(bus_if.imem_rd), 64'd0);
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        @(negedge clk);
        check("after_pop_count", 64'(bus_if.count), 64'd3);
        check("after_pop_rd", 64'(bus_if.imem_rd), 64'd1);
        check("after_pop_addr", 64'(bus_if.imem_addr), 64'h18);

        // Redirect to 0x13 while byte2 of a word is in flight
        @(posedge clk); #1;
        bus_if.out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus_if.imem_rd && bus_if.imem_addr[1:0] == 2'd2) found = 1'b1;
        end
        check("find_byte2", 64'(found), 64'd1);
        @(posedge clk); #1;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h13;
        @(negedge clk);
        check("redirect_no_read", 64'(bus_if.imem_rd), 64'd0);
        @(posedge clk); #1;
        bus_if.redirect = 1'b0;
        restart_stream(32'h13);
        @(negedge clk);
        check("redir13_count", 64'(bus_if.count), 64'd0);
        check("redir13_rd", 64'(bus_if.imem_rd), 64'd1);
        check("redir13_addr", 64'(bus_if.imem_addr), 64'h10);
        pops0 = n_pops;
        repeat (20) @(negedge clk);
        check("redir13_progress", 64'(n_pops - pops0 >= 3), 64'd1);

        // Redirect to 0x1C: second word has out_pc 0x20 read from address 0
        @(posedge clk); #1;
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 32'h1C;
        @(posedge clk); #1;
        bus_if.redirect = 1'b0;
        restart_stream(32'h1C);
        pops0 = n_pops;
        repeat (20) @(negedge clk);
        check("redir1c_progress", 64'(n_pops - pops0 >= 3), 64'd1);

        // Asynchronous reset during byte1 of a word with a non-empty FIFO
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus_if.count != 3'd0 && bus_if.imem_rd && bus_if.imem_addr[1:0] == 2'd1) found = 1'b1;
        end
        check("find_byte1", 64'(found), 64'd1);
        reset = 1'b1;
        #1;
        check_all_zero("midword_reset");
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        bus_if.out_ready = 1'b1;
        restart_stream(RESET_PC);
        @(negedge clk);
        check("restart_rd", 64'(bus_if.imem_rd), 64'd1);
        check("restart_addr", 64'(bus_if.imem_addr), 64'd0);

        // Randomized traffic with random ready and random redirects
        pops0 = n_pops;
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk); #1;
            if (bus_if.redirect) begin
                bus_if.redirect = 1'b0;
                restart_stream(pend_pc);
            end
            if (c % 200 == 0) ready_pct = $urandom_range(10, 100);
            bus_if.out_ready = ($urandom_range(1, 100) <= ready_pct);
            if ($urandom_range(0, 39) == 0) begin
                pend_pc = $urandom();
                bus_if.redirect    = 1'b1;
                bus_if.redirect_pc = pend_pc;
            end
        end
        @(posedge clk); #1;
        if (bus_if.redirect) begin
            bus_if.redirect = 1'b0;
            restart_stream(pend_pc);
        end
        bus_if.out_ready = 1'b1;
        repeat (30) @(negedge clk);
        check("random_progress", 64'(n_pops - pops0 >= 100), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
